// File: rtl/cpu4_fetch_stage.sv
// cpu4 instruction-fetch front end: owns the PC, issues 1-cycle synchronous reads to i_memory,
// buffers returned words in a small FIFO and hands them to decode over valid/ready.
module cpu4_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        fetch_exc
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {RUN = 2'd0, HALTED = 2'd1, EXC = 2'd2} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          run;
  logic          kill;
  logic          pop;
  logic          push;
  logic [CW:0]   occupancy;

  // A pop in this cycle frees a slot, so credit it when deciding whether to issue a read;
  // this is what lets two entries sustain one instruction per cycle.
  always_comb begin
    run       = (state == RUN);
    kill      = redirect | halt;
    pop       = (count != {CW{1'b0}}) & id_ready;
    push      = rst_ & run & inflight & ~kill;
    occupancy = (CW + 1)'(count) + (CW + 1)'(inflight) - (CW + 1)'(pop);
    imem_req  = rst_ & run & ~kill & (occupancy < DEPTH_W);
    imem_addr = pc;
    if_valid  = (count != {CW{1'b0}});
    fetch_exc = (state == EXC);
    if (if_valid) begin
      if_instr = buf_instr[rd_ptr];
      if_pc    = buf_pc[rd_ptr];
    end else begin
      if_instr = 32'h0000_0000;
      if_pc    = 32'h0000_0000;
    end
  end

  // Control: state, PC, in-flight tracking and FIFO occupancy.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state       <= RUN;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0000_0000;
      count       <= {CW{1'b0}};
      rd_ptr      <= {PW{1'b0}};
      wr_ptr      <= {PW{1'b0}};
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            state    <= HALTED;
            inflight <= 1'b0;
            count    <= {CW{1'b0}};
            rd_ptr   <= {PW{1'b0}};
            wr_ptr   <= {PW{1'b0}};
          end else if (redirect) begin
            if (redirect_pc[1:0] != 2'b00) begin
              state <= EXC;
            end else begin
              pc <= redirect_pc;
            end
            inflight <= 1'b0;
            count    <= {CW{1'b0}};
            rd_ptr   <= {PW{1'b0}};
            wr_ptr   <= {PW{1'b0}};
          end else begin
            inflight <= imem_req;
            if (imem_req) begin
              pc          <= pc + 32'd4;
              inflight_pc <= pc;
            end
            if (push) begin
              wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
              rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
          end
        end
        default: begin
          inflight <= 1'b0;
          count    <= {CW{1'b0}};
          rd_ptr   <= {PW{1'b0}};
          wr_ptr   <= {PW{1'b0}};
        end
      endcase
    end
  end

  // FIFO storage, tagged with the address each word was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_cpu4_fetch_stage.sv
// Self-checking bench for cpu4_fetch_stage: queue-based reference model plus directed pins.
module tb_cpu4_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_, redirect, halt, id_ready;
  logic [31:0] redirect_pc;
  logic        a_req, a_valid, a_exc;
  logic [31:0] a_addr, a_rdata, a_instr, a_pc;
  logic        b_rst_, b_id_ready;
  logic        b_req, b_valid, b_exc;
  logic [31:0] b_addr, b_rdata, b_instr, b_pc;

  cpu4_fetch_stage dut_a (
    .clk(clk), .rst_(rst_), .imem_req(a_req), .imem_addr(a_addr), .imem_rdata(a_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .if_valid(a_valid),
    .if_instr(a_instr), .if_pc(a_pc), .id_ready(id_ready), .fetch_exc(a_exc)
  );

  cpu4_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_b (
    .clk(clk), .rst_(b_rst_), .imem_req(b_req), .imem_addr(b_addr), .imem_rdata(b_rdata),
    .redirect(1'b0), .redirect_pc(32'h0000_0000), .halt(1'b0), .if_valid(b_valid),
    .if_instr(b_instr), .if_pc(b_pc), .id_ready(b_id_ready), .fetch_exc(b_exc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Instruction memories: 1-cycle synchronous read, poison when not requested.
  always @(posedge clk) begin
    a_rdata <= a_req ? mem_word(a_addr) : 32'hDEAD_BEEF;
    b_rdata <= b_req ? mem_word(b_addr) : 32'hDEAD_BEEF;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=run 1=halted 2=exception; queue holds fetched addresses in order.
  int          m_mode = 0;
  logic [31:0] m_pc = 32'h0000_0000;
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_pc = 32'h0000_0000;
  logic [31:0] m_q[$];
  bit          armed = 1'b0;

  always @(negedge clk) begin : compare
    bit e_valid, e_pop, e_req;
    e_valid = (m_q.size() > 0);
    e_pop   = e_valid && id_ready;
    e_req   = rst_ && (m_mode == 0) && !redirect && !halt &&
              ((m_q.size() + int'(m_pend) - int'(e_pop)) < 2);
    if (armed) begin
      chk("model_valid", 32'(a_valid), 32'(e_valid));
      chk("model_req", 32'(a_req), 32'(e_req));
      chk("model_addr", a_addr, m_pc);
      chk("model_exc", 32'(a_exc), 32'(m_mode == 2));
      if (e_valid) begin
        chk("model_if_pc", a_pc, m_q[0]);
        chk("model_if_instr", a_instr, mem_word(m_q[0]));
      end
    end
    if (!rst_) begin
      m_mode = 0; m_pc = 32'h0000_0000; m_pend = 1'b0; m_q.delete(); armed = 1'b1;
    end else if (armed && m_mode == 0) begin
      if (halt) begin
        m_mode = 1; m_pend = 1'b0; m_q.delete();
      end else if (redirect) begin
        if (redirect_pc[1:0] != 2'b00) m_mode = 2;
        else m_pc = redirect_pc;
        m_pend = 1'b0; m_q.delete();
      end else begin
        if (e_pop) void'(m_q.pop_front());
        if (m_pend) m_q.push_back(m_pend_pc);
        m_pend = e_req;
        if (e_req) begin
          m_pend_pc = m_pc;
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] t1_addr [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] t6_addr [5] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
  logic [31:0] t6_pc   [5] = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};

  initial begin
    rst_ = 1'b0; redirect = 1'b0; halt = 1'b0; id_ready = 1'b0; redirect_pc = 32'h0;
    b_rst_ = 1'b0; b_id_ready = 1'b1;
    repeat (3) tick();
    rst_ = 1'b1; id_ready = 1'b1;

    // Reset release: sequential fetch, first word two cycles after the first request.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_addr", a_addr, t1_addr[i]);
      chk("t1_req", 32'(a_req), 32'd1);
      chk("t1_valid", 32'(a_valid), (i >= 2) ? 32'd1 : 32'd0);
      if (i >= 2) chk("t1_pc", a_pc, t1_addr[i-2]);
      tick();
    end

    // Back-pressure: two words held, fetch stops, then drain.
    id_ready = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk("t2_valid", 32'(a_valid), 32'd1);
    chk("t2_req", 32'(a_req), 32'd0);
    chk("t2_held", 32'(m_q.size()), 32'd2);
    tick();
    id_ready = 1'b1;
    repeat (8) tick();

    // Redirect with a read in flight.
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    chk("t3_req_redir", 32'(a_req), 32'd0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("t3_req", 32'(a_req), 32'd1);
    chk("t3_addr", a_addr, 32'h40);
    chk("t3_valid0", 32'(a_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("t3_valid1", 32'(a_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("t3_valid2", 32'(a_valid), 32'd1);
    chk("t3_pc", a_pc, 32'h40);
    tick();

    // Random run with aligned redirects and random back-pressure.
    for (int i = 0; i < 300; i++) begin
      id_ready    = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom() & 32'hFFFF_FFFC;
      tick();
    end
    redirect = 1'b0; id_ready = 1'b1;
    repeat (4) tick();

    // Halt together with redirect: halt wins.
    halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    halt = 1'b0; redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_valid", 32'(a_valid), 32'd0);
      chk("t5_req", 32'(a_req), 32'd0);
      chk("t5_exc", 32'(a_exc), 32'd0);
      tick();
    end

    // Misaligned redirect: sticky exception, fetch stops.
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    repeat (4) tick();
    redirect = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_exc", 32'(a_exc), 32'd1);
      chk("t4_req", 32'(a_req), 32'd0);
      chk("t4_valid", 32'(a_valid), 32'd0);
      tick();
    end

    // Random run with resets, halts and misaligned targets.
    for (int i = 0; i < 600; i++) begin
      rst_        = ($urandom_range(0, 49) != 0);
      halt        = ($urandom_range(0, 99) == 0);
      redirect    = ($urandom_range(0, 14) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      id_ready    = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst_ = 1'b1; halt = 1'b0; redirect = 1'b0; id_ready = 1'b1;

    // PC wrap on the second instance, then reset mid-stream.
    b_rst_ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_addr", b_addr, t6_addr[i]);
      chk("t6_valid", 32'(b_valid), (i >= 2) ? 32'd1 : 32'd0);
      if (i >= 2) begin
        chk("t6_pc", b_pc, t6_pc[i]);
        chk("t6_instr", b_instr, mem_word(t6_pc[i]));
      end
      tick();
    end
    b_rst_ = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_rst_req", 32'(b_req), 32'd0);
    chk("t6_rst_valid", 32'(b_valid), 32'd0);
    chk("t6_rst_pc", b_pc, 32'h0);
    chk("t6_rst_instr", b_instr, 32'h0);
    chk("t6_rst_exc", 32'(b_exc), 32'd0);
    chk("t6_rst_addr", b_addr, 32'hFFFF_FFF8);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
